alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
// PURPOSE
//  Initiator side of the ALU command interface. Accepts operation requests on a valid/ready port
//  and drives the combinational ALU's A/B/command inputs. Holds them SETTLE_CYCLES, then captures the
//  15-bit result. Sequences wide multiply (cmd 3 then cmd 4) into one 30-bit result.
//  Sits between the datapath controller and the ALU; it is the only agent that drives the ALU.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each ALU command is held before result capture; legal range 1..15
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   driver can accept; high only in IDLE
//  req_op       in   3   0 ADD,1 SUB,2 AND,3 MP0,4 MP1,5 DIV,6 MOD,7 MULW (driver-level op)
//  req_a        in   16  operand A, ALU operand format (bit15 sign, [15:1] magnitude)
//  req_b        in   16  operand B, same format
//  alu_a        out  16  to ALU A
//  alu_b        out  16  to ALU B
//  alu_command  out  3   to ALU command; never driven to 7
//  alu_result   in   15  from ALU result
//  resp_valid   out  1   response present
//  resp_ready   in   1   consumer accepts response
//  resp_data    out  30  result
//  resp_err     out  1   1 = divide/modulo by zero; resp_data = 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; any in-flight op is discarded and produces no response.
//  FSM: IDLE -> EXEC -> [EXEC_LO if MULW] -> RESP -> IDLE; IDLE -> RESP directly on a zero-divisor error.
//  Accept on the edge E where req_valid && req_ready; operands and op are latched at E.
//  Op 5/6 with req_b[15:1]==0: ALU not driven (alu_* keep prior values); resp_valid=1, resp_err=1 from E+1.
//  Ops 0-6: alu_* driven from E; alu_result captured at E+SETTLE_CYCLES; resp_valid from E+SETTLE_CYCLES.
//  MULW: command 3 from E; hi captured at E+S; command 4 from E+S; lo captured at E+2S.
//   resp_data={hi,lo}, resp_valid from E+2S.
//  Width rules: ops 0,1,5,6 sign-extend alu_result[14] to 30 bits; ops 2,3,4 zero-extend.
//  The settle counter is 4 bits; it reloads on every command change and never wraps inside an op.
//  RESP: resp_data/resp_err are held stable until resp_valid && resp_ready.
//   Then IDLE; req_ready=1 the following cycle. A new request cannot overlap a pending response.
//  alu_a/alu_b/alu_command hold their last driven values in IDLE and RESP; there are no spurious toggles.
//  req_* are ignored while req_ready=0. resp_ready is ignored while resp_valid=0.
// CONFIGURATION
//  ALU_CMD_DRIVER_STATS_EN defined: adds outputs stat_ops (16) and stat_errs (8).
//   stat_ops increments on every response handshake; stat_errs on error responses.
//   Both saturate at all-ones and are cleared by reset.
//  Not defined: these ports and their counters are absent. Timing and all other behaviour are identical.
// STRUCTURE
//  alu_pkg: op-code localparams (OP_ADD..OP_MULW), ALU_OPW=16, ALU_RESW=15, RESP_W=30, FSM state encoding.
//  Sub-module alu_cmd_driver_stats (counters), instantiated only under ALU_CMD_DRIVER_STATS_EN.
//  FSM, settle counter and capture registers stay inline.
// TESTING (bench instantiates the team ALU behind the driver, SETTLE_CYCLES=2)
//  ADD a=16'h000C b=16'h0004 -> alu_command=0 from E; resp_valid at E+2; resp_data=30'd8; err=0.
//  MULW a=16'h0400 b=16'h0200 -> cmd 3 over [E,E+2), cmd 4 over [E+2,E+4).
//   resp_data=30'h0002_0000 at E+4.
//  DIV b=16'h0001 -> resp at E+1, resp_err=1, resp_data=0; alu_command unchanged.
//  resp_ready held low 5 cycles after resp_valid -> resp_data stable and req_ready=0 throughout.
//   Then handshake -> req_ready=1 next cycle.
//  reset pulsed at E+3 of MULW -> all outputs 0 immediately.
//   No response is emitted; the next ADD completes normally.
//  STATS_EN: 3 ops + 1 div-by-zero -> stat_ops=4, stat_errs=1; forced to 16'hFFFF stays at 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, widths, FSM encoding and result-width helpers for the ALU command driver.
package alu_pkg;

  localparam int ALU_OPW  = 16;
  localparam int ALU_RESW = 15;
  localparam int RESP_W   = 30;

  // Driver-level op codes; 0..6 map 1:1 onto ALU commands, MULW is sequenced as MP0 then MP1.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_MP0  = 3'd3;
  localparam logic [2:0] OP_MP1  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_MOD  = 3'd6;
  localparam logic [2:0] OP_MULW = 3'd7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXEC    = 2'd1;
  localparam logic [1:0] ST_EXEC_LO = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  function automatic logic f_is_divmod(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic [2:0] f_first_cmd(input logic [2:0] op);
    return (op == OP_MULW) ? OP_MP0 : op;
  endfunction

  // Arithmetic results are signed 15-bit values; logical and product slices are unsigned.
  function automatic logic [RESP_W-1:0] f_extend(input logic [2:0] op,
                                                 input logic [ALU_RESW-1:0] res);
    logic [RESP_W-1:0] v;
    case (op)
      OP_ADD, OP_SUB, OP_DIV, OP_MOD: v = {{(RESP_W-ALU_RESW){res[ALU_RESW-1]}}, res};
      default:                        v = {{(RESP_W-ALU_RESW){1'b0}}, res};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_stats.sv
// Saturating response/error counters for the ALU command driver (used when ALU_CMD_DRIVER_STATS_EN is defined).
module alu_cmd_driver_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_resp_hs,
  input  logic        i_resp_err,
  output logic [15:0] o_stat_ops,
  output logic [7:0]  o_stat_errs
);

  logic [15:0] r_ops;
  logic [7:0]  r_errs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ops  <= '0;
      r_errs <= '0;
    end else if (i_resp_hs) begin
      if (r_ops != '1) r_ops <= r_ops + 16'd1;
      if (i_resp_err && (r_errs != '1)) r_errs <= r_errs + 8'd1;
    end
  end

  assign o_stat_ops  = r_ops;
  assign o_stat_errs = r_errs;

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the combinational ALU: latches a request, holds ALU inputs SETTLE_CYCLES, captures the result.
// Define ALU_CMD_DRIVER_STATS_EN to add the stat_ops/stat_errs counter outputs.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ALU_OPW-1:0]  req_a,
  input  logic [ALU_OPW-1:0]  req_b,
  output logic [ALU_OPW-1:0]  alu_a,
  output logic [ALU_OPW-1:0]  alu_b,
  output logic [2:0]          alu_command,
  input  logic [ALU_RESW-1:0] alu_result,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [RESP_W-1:0]   resp_data,
  output logic                resp_err,
`ifdef ALU_CMD_DRIVER_STATS_EN
  output logic [15:0]         stat_ops,
  output logic [7:0]          stat_errs,
`endif
  output logic [1:0]          o_dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready; a response
  // transfers on a rising edge where resp_valid && resp_ready. Neither side may withdraw early.

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_req_ready;
  logic [2:0]          r_op;
  logic [3:0]          r_cnt;
  logic [ALU_RESW-1:0] r_hi;
  logic [ALU_OPW-1:0]  r_alu_a;
  logic [ALU_OPW-1:0]  r_alu_b;
  logic [2:0]          r_alu_cmd;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [RESP_W-1:0]   r_resp_data;

  logic w_accept;
  logic w_div0;
  logic w_settled;
  logic w_resp_hs;

  assign w_accept  = req_valid && r_req_ready;
  assign w_div0    = f_is_divmod(req_op) && (req_b[ALU_OPW-1:1] == '0);
  assign w_settled = (r_cnt == 4'd1);
  assign w_resp_hs = r_resp_valid && resp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = w_div0 ? ST_RESP : ST_EXEC;
      ST_EXEC:    if (w_settled) w_state_nxt = (r_op == OP_MULW) ? ST_EXEC_LO : ST_RESP;
      ST_EXEC_LO: if (w_settled) w_state_nxt = ST_RESP;
      ST_RESP:    if (w_resp_hs) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_op         <= OP_ADD;
      r_cnt        <= '0;
      r_hi         <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cmd    <= OP_ADD;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= req_op;
            // A zero divisor never reaches the ALU, so its inputs keep their last values.
            if (!w_div0) begin
              r_alu_a   <= req_a;
              r_alu_b   <= req_b;
              r_alu_cmd <= f_first_cmd(req_op);
              r_cnt     <= SETTLE_LD;
            end
          end
        end
        ST_EXEC: begin
          if (w_settled) begin
            if (r_op == OP_MULW) begin
              r_hi      <= alu_result;
              r_alu_cmd <= OP_MP1;
              r_cnt     <= SETTLE_LD;
            end else begin
              r_resp_data  <= f_extend(r_op, alu_result);
              r_resp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_EXEC_LO: begin
          if (w_settled) begin
            r_resp_data  <= {r_hi, alu_result};
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Only the divide-by-zero path enters RESP with no response raised yet.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_command = r_alu_cmd;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_data   = r_resp_data;
  assign o_dbg_state = r_state;

`ifdef ALU_CMD_DRIVER_STATS_EN
  alu_cmd_driver_stats u_stats (
    .clk         (clk),
    .reset       (reset),
    .i_resp_hs   (w_resp_hs),
    .i_resp_err  (r_resp_err),
    .o_stat_ops  (stat_ops),
    .o_stat_errs (stat_errs)
  );
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: team ALU model behind the driver, scoreboard fed by a reference model.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_command;
  logic [14:0] alu_result;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [29:0] resp_data;
  logic        resp_err;
  logic [1:0]  dbg_state;
`ifdef ALU_CMD_DRIVER_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_errs;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [30:0] exp_q[$];
  logic rr_force = 1'b1;
  logic rr_val = 1'b1;
  int exp_ops = 0;
  int exp_errs = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  alu_cmd_driver #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_command (alu_command),
    .alu_result  (alu_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
`ifdef ALU_CMD_DRIVER_STATS_EN
    .stat_ops    (stat_ops),
    .stat_errs   (stat_errs),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- team ALU and reference model ----------------
  function automatic int sm2int(input logic [15:0] x);
    int m;
    m = int'(x[15:1]);
    return x[15] ? -m : m;
  endfunction

  function automatic logic [14:0] team_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] cmd);
    int va, vb, ma, mb, r;
    va = sm2int(a); vb = sm2int(b);
    ma = int'(a[15:1]); mb = int'(b[15:1]);
    case (cmd)
      3'd0:    r = va + vb;
      3'd1:    r = va - vb;
      3'd2:    r = ma & mb;
      3'd3:    r = (ma * mb) / 32768;
      3'd4:    r = (ma * mb) % 32768;
      3'd5:    r = (vb == 0) ? 0 : va / vb;
      3'd6:    r = (vb == 0) ? 0 : va % vb;
      default: r = 0;
    endcase
    return 15'(r);
  endfunction

  assign alu_result = team_alu(alu_a, alu_b, alu_command);

  // Wrap an integer into the signed 15-bit range, then widen to 30 bits.
  function automatic logic [29:0] signed15(input int s);
    int w;
    w = s & 32'h7FFF;
    if (w >= 16384) w = w - 32768;
    return 30'(w);
  endfunction

  function automatic logic [30:0] ref_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    int ma, mb, va, vb;
    logic [29:0] d;
    ma = int'(a[15:1]); mb = int'(b[15:1]);
    va = sm2int(a); vb = sm2int(b);
    if (((op == OP_DIV) || (op == OP_MOD)) && (mb == 0)) return {1'b1, 30'd0};
    case (op)
      OP_ADD:  d = signed15(va + vb);
      OP_SUB:  d = signed15(va - vb);
      OP_AND:  d = 30'(ma & mb);
      OP_MP0:  d = 30'((ma * mb) / 32768);
      OP_MP1:  d = 30'((ma * mb) % 32768);
      OP_DIV:  d = signed15(va / vb);
      OP_MOD:  d = signed15(va % vb);
      default: d = 30'(ma * mb);
    endcase
    return {1'b0, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  always begin
    @(posedge clk);
    #1;
    resp_ready = rr_force ? rr_val : 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 200) break;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(ref_model(op, a, b));
      #1;
      req_valid = 1'b0;
      req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_data", {2'd0, resp_data}, 32'd0);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    check("rst_alu_cmd", {29'd0, alu_command}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
`ifdef ALU_CMD_DRIVER_STATS_EN
    check("rst_stat_ops", {16'd0, stat_ops}, 32'd0);
`endif
    exp_q.delete();
    exp_ops = 0; exp_errs = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_resp_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!resp_valid && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rr_force = 1'b1; rr_val = 1'b1;
    while ((exp_q.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [30:0] e;
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got data 0x%0h err %0b, expected no response", resp_data, resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp", {1'b0, resp_err, resp_data}, {1'b0, e});
        check("alu_cmd_not7", {31'd0, (alu_command == 3'd7)}, 32'd0);
        if (exp_ops < 65535) exp_ops++;
        if (e[30] && (exp_errs < 255)) exp_errs++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [30:0] e_hold;

    #2;
    do_reset();

    // ADD: 6 + 2 = 8, response two cycles after accept
    rr_force = 1'b1; rr_val = 1'b1;
    send(OP_ADD, 16'h000C, 16'h0004);
    @(negedge clk);
    check("add_cmd_E", {29'd0, alu_command}, 32'd0);
    check("add_a_E", {16'd0, alu_a}, 32'h000C);
    check("add_b_E", {16'd0, alu_b}, 32'h0004);
    check("add_req_ready_E", {31'd0, req_ready}, 32'd0);
    check("add_valid_E", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("add_valid_E1", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("add_valid_E2", {31'd0, resp_valid}, 32'd1);
    check("add_data_E2", {2'd0, resp_data}, 32'd8);
    check("add_err_E2", {31'd0, resp_err}, 32'd0);

    // MULW: 512 * 256, MP0 then MP1
    send(OP_MULW, 16'h0400, 16'h0200);
    @(negedge clk);
    check("mulw_cmd_E", {29'd0, alu_command}, 32'd3);
    @(negedge clk);
    check("mulw_cmd_E1", {29'd0, alu_command}, 32'd3);
    @(negedge clk);
    check("mulw_cmd_E2", {29'd0, alu_command}, 32'd4);
    check("mulw_valid_E2", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("mulw_cmd_E3", {29'd0, alu_command}, 32'd4);
    check("mulw_valid_E3", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("mulw_valid_E4", {31'd0, resp_valid}, 32'd1);
    check("mulw_data_E4", {2'd0, resp_data}, 32'h0002_0000);

    // DIV by zero magnitude: error one cycle after accept, ALU untouched
    send(OP_DIV, 16'h1234, 16'h0001);
    @(negedge clk);
    check("div0_valid_E", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("div0_valid_E1", {31'd0, resp_valid}, 32'd1);
    check("div0_err_E1", {31'd0, resp_err}, 32'd1);
    check("div0_data_E1", {2'd0, resp_data}, 32'd0);
    check("div0_cmd_kept", {29'd0, alu_command}, 32'd4);
    check("div0_a_kept", {16'd0, alu_a}, 32'h0400);
    check("div0_b_kept", {16'd0, alu_b}, 32'h0200);

    // Back-pressure: response held while resp_ready stays low
    rr_val = 1'b0;
    a = 16'($urandom); b = 16'($urandom) | 16'h0002;
    e_hold = ref_model(OP_SUB, a, b);
    send(OP_SUB, a, b);
    wait_resp_valid("hold_first_valid", 20);
    repeat (5) begin
      @(negedge clk);
      check("hold_data", {2'd0, resp_data}, {2'd0, e_hold[29:0]});
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rr_val = 1'b1;
    @(negedge clk);
    check("hold_hs_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_hs_valid", {31'd0, resp_valid}, 32'd0);

    // Reset three cycles into a MULW: no response, then a normal ADD
    send(OP_MULW, 16'h1234, 16'h0F0E);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    do_reset();
    send(OP_ADD, 16'h0010, 16'h8006);
    drain();

    // Randomized traffic with random back-pressure
    rr_force = 1'b0;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom); b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: b = {1'($urandom), 15'd0} | 16'($urandom_range(0, 1));
        1: a = 16'hFFFE;
        2: b = 16'h7FFE;
        default: ;
      endcase
      send(op, a, b);
    end
    drain();

`ifdef ALU_CMD_DRIVER_STATS_EN
    check("stat_ops_model", {16'd0, stat_ops}, 32'(exp_ops));
    check("stat_errs_model", {24'd0, stat_errs}, 32'(exp_errs));
    do_reset();
    send(OP_ADD, 16'h0002, 16'h0004);
    send(OP_AND, 16'h00FF, 16'h0F0F);
    send(OP_MULW, 16'h0006, 16'h0008);
    send(OP_MOD, 16'h0022, 16'h8000);
    drain();
    check("stat_ops_4", {16'd0, stat_ops}, 32'd4);
    check("stat_errs_1", {24'd0, stat_errs}, 32'd1);
    @(negedge clk);
    force dut.u_stats.r_ops = 16'hFFFF;
    @(negedge clk);
    release dut.u_stats.r_ops;
    send(OP_ADD, 16'h0002, 16'h0002);
    drain();
    check("stat_ops_sat", {16'd0, stat_ops}, 32'h0000_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
